// File: rtl/mips_pkg.sv
// Shared encodings for the hi/lo multiply unit: register-file write-port codes,
// instruction op codes and the multiplier FSM states.
package mips_pkg;

    localparam logic [1:0] MUL_NONE = 2'd0;
    localparam logic [1:0] MUL_LOAD = 2'd1;
    localparam logic [1:0] MUL_ACC  = 2'd2;

    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_MADD  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIX   = 2'd2,
        WRITE = 2'd3
    } mult_state_t;

endpackage

// File: rtl/mult_shift_add_dp.sv
// Shift-add multiplier datapath: multiplicand, multiplier and accumulator registers
// plus the step adder. Operates on magnitudes; optional negation on the result path.
module mult_shift_add_dp #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               negate,
    input  logic [WIDTH-1:0]   a_mag,
    input  logic [WIDTH-1:0]   b_mag,
    output logic [2*WIDTH-1:0] result
);

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (load) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_mag};
            mplier_q <= b_mag;
            acc_q    <= '0;
        end else if (step) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

    assign result = negate ? (~acc_q + (2*WIDTH)'(1)) : acc_q;

endmodule

// File: rtl/mult_div_writer.sv
// Multi-cycle multiplier that issues one hi/lo write (load or accumulate) per operation.
// Optional macro MULT_SIGNED_EN enables signed operands via is_signed; otherwise all unsigned.
module mult_div_writer
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             write_enable,
    output logic [1:0]       mul,
    output logic [WIDTH-1:0] write_data_1,
    output logic [WIDTH-1:0] write_data_2
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mult_state_t      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       op_q, op_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] wd_lo_q, wd_lo_d;
    logic [WIDTH-1:0] wd_hi_q, wd_hi_d;

    logic               signed_mode;
    logic               op_legal;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               dp_load, dp_step, dp_negate;
    logic [2*WIDTH-1:0] dp_result;

`ifdef MULT_SIGNED_EN
    assign signed_mode = is_signed;
`else
    assign signed_mode = is_signed & 1'b0;
`endif

    // Most-negative input negates to itself, which read unsigned is exactly 2^(WIDTH-1).
    assign a_mag    = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign b_mag    = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    assign op_legal = (op == OP_MULT) || (op == OP_MADD);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        sign_d    = sign_q;
        wd_lo_d   = wd_lo_q;
        wd_hi_d   = wd_hi_q;
        dp_load   = 1'b0;
        dp_step   = 1'b0;
        dp_negate = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && op_legal) begin
                    state_d = CALC;
                    op_d    = op;
                    sign_d  = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    count_d = '0;
                    dp_load = 1'b1;
                end
            end
            CALC: begin
                dp_step = 1'b1;
                if (count_q == LAST_CNT) begin
                    count_d = '0;
                    state_d = FIX;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            FIX: begin
                dp_negate          = sign_q;
                {wd_hi_d, wd_lo_d} = dp_result;
                state_d            = WRITE;
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            op_q    <= 2'b00;
            sign_q  <= 1'b0;
            wd_lo_q <= '0;
            wd_hi_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
            wd_lo_q <= wd_lo_d;
            wd_hi_q <= wd_hi_d;
        end
    end

    mult_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .rst    (rst),
        .load   (dp_load),
        .step   (dp_step),
        .negate (dp_negate),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .result (dp_result)
    );

    assign busy         = (state_q != IDLE);
    assign done         = (state_q == WRITE);
    assign write_enable = (state_q == WRITE);
    assign mul          = (state_q != WRITE) ? MUL_NONE :
                          (op_q == OP_MADD)  ? MUL_ACC  : MUL_LOAD;
    assign write_data_1 = wd_lo_q;
    assign write_data_2 = wd_hi_q;

endmodule

// File: tb/tb_mult_div_writer.sv
// Directed-vector bench for mult_div_writer; expected products are hand-computed constants.
module tb_mult_div_writer;
    import mips_pkg::*;

    localparam int WIDTH = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic        is_signed;
    logic [31:0] a, b;
    logic        busy, done, write_enable;
    logic [1:0]  mul;
    logic [31:0] write_data_1, write_data_2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mult_div_writer #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .is_signed    (is_signed),
        .a            (a),
        .b            (b),
        .busy         (busy),
        .done         (done),
        .write_enable (write_enable),
        .mul          (mul),
        .write_data_1 (write_data_1),
        .write_data_2 (write_data_2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Issue one op, scramble operands after acceptance, then check the WRITE cycle.
    task automatic run_op(input string tag, input logic [1:0] op_v, input logic sgn,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [63:0] exp_prod, input logic [1:0] exp_mul);
        int  n;
        bit  found;
        bit  busy_gap;
        @(negedge clk);
        start = 1'b1; op = op_v; is_signed = sgn; a = av; b = bv;
        n = cyc;
        @(negedge clk);
        start = 1'b0; op = 2'b11; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
        found = 1'b0; busy_gap = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (write_enable) begin
                found = 1'b1;
                break;
            end
            if (!busy) busy_gap = 1'b1;
            @(negedge clk);
        end
        check({tag, "_found"},   found, 1);
        check({tag, "_latency"}, cyc - n, 34);
        check({tag, "_busygap"}, busy_gap, 0);
        check({tag, "_done"},    done, 1);
        check({tag, "_mul"},     mul, exp_mul);
        check({tag, "_data"},    {write_data_2, write_data_1}, exp_prod);
        @(negedge clk);
        check({tag, "_we_after"},   write_enable, 0);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_mul_after"},  mul, MUL_NONE);
        check({tag, "_data_hold"},  {write_data_2, write_data_1}, exp_prod);
    endtask

    initial begin
        int  writes;
        int  wr_at;
        bit  busy_gap;
        bit  idle35;
        bit  busy36;
        bit  seen;
        bit  found;
        logic [63:0] exp_neg2x7;
        logic [63:0] exp_min_x3;

`ifdef MULT_SIGNED_EN
        exp_neg2x7 = 64'hFFFF_FFFF_FFFF_FFF2;
        exp_min_x3 = 64'hFFFF_FFFE_8000_0000;
`else
        exp_neg2x7 = 64'h0000_0006_FFFF_FFF2;
        exp_min_x3 = 64'h0000_0001_8000_0000;
`endif

        rst = 1'b1; start = 1'b0; op = 2'b00; is_signed = 1'b0; a = '0; b = '0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_we",   write_enable, 0);
        check("rst_mul",  mul, 0);
        check("rst_data", {write_data_2, write_data_1}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);

        run_op("mult_3x5",     OP_MULT, 1'b0, 32'd3,          32'd5,          64'h0000_0000_0000_000F, MUL_LOAD);
        run_op("mult_s_n2x7",  OP_MULT, 1'b1, 32'hFFFF_FFFE,  32'd7,          exp_neg2x7,              MUL_LOAD);
        run_op("madd_ffxff",   OP_MADD, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, MUL_ACC);
        run_op("mult_s_minsq", OP_MULT, 1'b1, 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000, MUL_LOAD);
        run_op("madd_s_minx3", OP_MADD, 1'b1, 32'h8000_0000,  32'd3,          exp_min_x3,              MUL_ACC);
        run_op("mult_zero",    OP_MULT, 1'b0, 32'd0,          32'h0000_1234,  64'h0,                   MUL_LOAD);

        // Illegal op codes must never start an operation.
        @(negedge clk);
        start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd9;
        @(negedge clk);
        op = 2'b00;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            if (busy || write_enable) seen = 1'b1;
            @(negedge clk);
        end
        check("illegal_op_activity", seen, 0);

        // start held high for 40 cycles: one accept at 0, next accept at 35.
        start = 1'b1; op = OP_MULT; is_signed = 1'b0; a = 32'd3; b = 32'd5;
        writes = 0; wr_at = -1; busy_gap = 1'b0; idle35 = 1'b0; busy36 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (write_enable) begin
                writes++;
                if (wr_at < 0) wr_at = i;
            end
            if (i >= 1 && i <= 34 && !busy) busy_gap = 1'b1;
            if (i == 35) idle35 = !busy;
            if (i == 36) busy36 = busy;
            @(negedge clk);
        end
        start = 1'b0;
        check("pulse_writes",   writes, 1);
        check("pulse_write_at", wr_at, 34);
        check("pulse_busygap",  busy_gap, 0);
        check("pulse_idle35",   idle35, 1);
        check("pulse_busy36",   busy36, 1);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (write_enable) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("pulse_second_found", found, 1);
        check("pulse_second_data",  {write_data_2, write_data_1}, 64'hF);
        @(negedge clk);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_we",   write_enable, 0);
        check("midrst_mul",  mul, 0);
        check("midrst_data", {write_data_2, write_data_1}, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            if (write_enable || busy) seen = 1'b1;
            @(negedge clk);
        end
        check("midrst_no_write", seen, 0);
        run_op("after_rst", OP_MULT, 1'b0, 32'd6, 32'd7, 64'd42, MUL_LOAD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
